// File: rtl/sel_arbiter_2_if.sv
// Handshake bundle for sel_arbiter_2: two request lanes in, one registered 2-lane bus out.
// Latency: none (pure wiring).
// Backpressure: in_ready per lane; out_ready from the consumer of the registered bus.
interface sel_arbiter_2_if #(
    parameter int WIDTH = 2
);
    logic [1:0]            in_valid;
    logic [1:0]            in_ready;
    logic [1:0][WIDTH-1:0] in_data;
    logic [1:0][WIDTH-1:0] out_data;
    logic                  out_sel;
    logic                  out_valid;
    logic                  out_ready;

    // Arbiter side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/sel_arbiter_2.sv
// Two-lane round-robin arbiter with burst hold feeding a registered mux/demux operand stage.
// Latency: 1 cycle from accept to out_*; 1 beat/cycle while out_ready is high.
// Backpressure: out_ready low with a held beat stalls everything and drops in_ready. Optional stats: SEL_ARBITER_2_STATS_EN.
module sel_arbiter_2 #(
    parameter int WIDTH     = 2,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef SEL_ARBITER_2_STATS_EN
    input  logic        stat_clr,
    output logic [15:0] stat_cnt0,
    output logic [15:0] stat_cnt1,
`endif
    sel_arbiter_2_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last;
    logic [CW-1:0]         r_burst_cnt;
    logic [CW-1:0]         w_burst_nxt;
    logic                  r_out_valid;
    logic                  r_out_sel;
    logic [1:0][WIDTH-1:0] r_out_data;

    logic w_space;
    logic w_gnt_vld;
    logic w_gnt;
    logic w_own;
    logic w_acc;
    logic w_same_owner;

    assign w_space = !r_out_valid || bus.out_ready;
    assign w_acc   = w_space && w_gnt_vld;

    // Grant selection: alternate from idle, otherwise hold the owner until its burst cap is hit while the other lane waits
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        w_own     = (r_state == OWN1);
        if (r_state == IDLE) begin
            if (&bus.in_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt     = ~r_last;
            end else if (bus.in_valid[0]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b0;
            end else if (bus.in_valid[1]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b1;
            end
        end else begin
            if (bus.in_valid[w_own] && ((r_burst_cnt < BURST_MAX) || !bus.in_valid[~w_own])) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_own;
            end else if (bus.in_valid[~w_own]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = ~w_own;
            end
        end
    end

    // Ready is one-hot on the granted lane and forced low while reset is asserted
    assign bus.in_ready[0] = rst_n && w_acc && !w_gnt;
    assign bus.in_ready[1] = rst_n && w_acc &&  w_gnt;

    assign w_same_owner = ((r_state == OWN0) && !w_gnt) || ((r_state == OWN1) && w_gnt);

    // Next state and burst count: accept moves ownership, an empty slot returns to IDLE, a stall holds
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        if (w_acc) begin
            w_state_nxt = w_gnt ? OWN1 : OWN0;
            if (w_same_owner) begin
                w_burst_nxt = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + 1'b1;
            end else begin
                w_burst_nxt = CW'(1);
            end
        end else if (w_space) begin
            w_state_nxt = IDLE;
            w_burst_nxt = '0;
        end
    end

    // Arbitration state register; last=1 so the first contended grant after reset goes to lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_last      <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            if (w_acc) begin
                r_last <= w_gnt;
            end
        end
    end

    // Output stage: only the granted lane is overwritten so the mux always sees stable operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sel   <= 1'b0;
            r_out_data  <= '0;
        end else if (w_acc) begin
            r_out_data[w_gnt] <= bus.in_data[w_gnt];
            r_out_sel         <= w_gnt;
            r_out_valid       <= 1'b1;
        end else if (w_space) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = r_out_sel;
    assign bus.out_data  = r_out_data;

`ifdef SEL_ARBITER_2_STATS_EN
    logic [15:0] r_stat_cnt0;
    logic [15:0] r_stat_cnt1;

    // Per-lane accepted-beat counters, saturating; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
        end else if (stat_clr) begin
            r_stat_cnt0 <= '0;
            r_stat_cnt1 <= '0;
        end else if (w_acc) begin
            if (!w_gnt && (r_stat_cnt0 != 16'hFFFF)) begin
                r_stat_cnt0 <= r_stat_cnt0 + 16'd1;
            end
            if (w_gnt && (r_stat_cnt1 != 16'hFFFF)) begin
                r_stat_cnt1 <= r_stat_cnt1 + 16'd1;
            end
        end
    end

    assign stat_cnt0 = r_stat_cnt0;
    assign stat_cnt1 = r_stat_cnt1;
`endif
endmodule

// File: tb/tb_sel_arbiter_2.sv
// Directed testbench for sel_arbiter_2 with hand-computed expectations.
// Latency: checks out_* one cycle after each accept.
// Backpressure: exercises out_ready stalls and burst-capped arbitration.
module tb_sel_arbiter_2;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    sel_arbiter_2_if #(.WIDTH(2)) bus ();

`ifdef SEL_ARBITER_2_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_cnt0;
    logic [15:0] stat_cnt1;
`endif

    sel_arbiter_2 #(.WIDTH(2), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef SEL_ARBITER_2_STATS_EN
        .stat_clr (stat_clr),
        .stat_cnt0(stat_cnt0),
        .stat_cnt1(stat_cnt1),
`endif
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 2'b11;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef SEL_ARBITER_2_STATS_EN
        stat_clr = 1'b0;
`endif
        #2;
        check_vec("rst_in_ready",  32'(bus.in_ready), 32'h0);
        check_vec("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_vec("rst_out_sel",   32'(bus.out_sel), 32'h0);
        check_vec("rst_out_data",  32'(bus.out_data), 32'h0);
        tick();
        tick();
        bus.in_valid = 2'b00;
        rst_n = 1'b1;

`ifdef SEL_ARBITER_2_STATS_EN
        bus.in_valid = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        bus.in_valid = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 2'b00;
        tick();
        check_vec("stat_cnt0_pre", 32'(stat_cnt0), 32'd5);
        check_vec("stat_cnt1_pre", 32'(stat_cnt1), 32'd3);
        bus.in_valid = 2'b01;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        bus.in_valid = 2'b00;
        check_vec("stat_cnt0_clr", 32'(stat_cnt0), 32'd0);
        check_vec("stat_cnt1_clr", 32'(stat_cnt1), 32'd0);
        tick();
`endif

        // Single lane-0 beat
        do_reset();
        bus.in_valid   = 2'b01;
        bus.in_data[0] = 2'h3;
        bus.out_ready  = 1'b1;
        #1;
        check_vec("t1_in_ready", 32'(bus.in_ready), 32'h1);
        tick();
        check_vec("t1_out_valid", 32'(bus.out_valid), 32'h1);
        check_vec("t1_out_sel",   32'(bus.out_sel), 32'h0);
        check_vec("t1_out_data0", 32'(bus.out_data[0]), 32'h3);
        bus.in_valid = 2'b00;
        tick();
        check_vec("t1_drain_valid", 32'(bus.out_valid), 32'h0);

        // Fairness: 4 beats lane 0, 4 beats lane 1, repeating, no bubbles
        do_reset();
        bus.in_data[0] = 2'h1;
        bus.in_data[1] = 2'h2;
        bus.in_valid   = 2'b11;
        for (int i = 0; i < 12; i++) begin
            #1;
            check_vec($sformatf("t2_in_ready_%0d", i), 32'(bus.in_ready), ((i / 4) % 2) ? 32'h2 : 32'h1);
            tick();
            check_vec($sformatf("t2_out_sel_%0d", i), 32'(bus.out_sel), 32'((i / 4) % 2));
            check_vec($sformatf("t2_out_valid_%0d", i), 32'(bus.out_valid), 32'h1);
        end
        bus.in_valid = 2'b00;
        tick();

        // Lane-0 stream with a 3-cycle out_ready stall
        bus.in_valid   = 2'b01;
        bus.in_data[0] = 2'h1;
        bus.out_ready  = 1'b1;
        #1;
        check_vec("t3_rdy_a", 32'(bus.in_ready), 32'h1);
        tick();
        check_vec("t3_data_a", 32'(bus.out_data[0]), 32'h1);
        bus.in_data[0] = 2'h2;
        #1;
        check_vec("t3_rdy_b", 32'(bus.in_ready), 32'h1);
        tick();
        check_vec("t3_data_b", 32'(bus.out_data[0]), 32'h2);
        bus.in_data[0] = 2'h3;
        bus.out_ready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_vec($sformatf("t3_stall_rdy_%0d", k), 32'(bus.in_ready), 32'h0);
            tick();
            check_vec($sformatf("t3_stall_data_%0d", k), 32'(bus.out_data[0]), 32'h2);
            check_vec($sformatf("t3_stall_sel_%0d", k), 32'(bus.out_sel), 32'h0);
            check_vec($sformatf("t3_stall_vld_%0d", k), 32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        check_vec("t3_rdy_c", 32'(bus.in_ready), 32'h1);
        tick();
        check_vec("t3_data_c", 32'(bus.out_data[0]), 32'h3);
        bus.in_valid = 2'b00;
        tick();
        check_vec("t3_drain_valid", 32'(bus.out_valid), 32'h0);

        // Lane 1 alone: 10 back-to-back beats, no burst cap
        bus.in_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            bus.in_data[1] = 2'(i);
            #1;
            check_vec($sformatf("t4_rdy_%0d", i), 32'(bus.in_ready), 32'h2);
            tick();
            check_vec($sformatf("t4_sel_%0d", i), 32'(bus.out_sel), 32'h1);
            check_vec($sformatf("t4_data1_%0d", i), 32'(bus.out_data[1]), 32'(i % 4));
        end
        bus.in_valid = 2'b00;
        tick();

        // Async reset during a lane-1 burst
        do_reset();
        bus.in_data[0] = 2'h1;
        bus.in_data[1] = 2'h2;
        bus.in_valid   = 2'b11;
        for (int i = 0; i < 6; i++) tick();
        check_vec("t5_pre_sel", 32'(bus.out_sel), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("t5_rst_valid", 32'(bus.out_valid), 32'h0);
        check_vec("t5_rst_sel",   32'(bus.out_sel), 32'h0);
        check_vec("t5_rst_data",  32'(bus.out_data), 32'h0);
        check_vec("t5_rst_rdy",   32'(bus.in_ready), 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_vec("t5_post_rdy", 32'(bus.in_ready), 32'h1);
        tick();
        check_vec("t5_post_sel",   32'(bus.out_sel), 32'h0);
        check_vec("t5_post_valid", 32'(bus.out_valid), 32'h1);
        bus.in_valid = 2'b00;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
